sram_frame_arbiter: RTL and testbench

//  Time-division arbiter for the single external 16-bit async SRAM shared by the delay effect (port A)
//  and the looper (port B). Each audio frame (i_frame_start = DACLRCK rise pulse) opens slot A, then

---
 rtl/sram_frame_arbiter.sv | 259 +++++++++++++++++++++++++
 tb/tb_sram_frame_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_frame_arbiter.sv
// Time-division owner of the shared external async SRAM: each audio frame opens slot A
// (delay effect) then slot B (looper); the owner issues single accesses sequenced here.
module sram_frame_arbiter #(
  parameter int ADDR_W       = 20,
  parameter int DATA_W       = 16,
  parameter int SLOT_TIMEOUT = 12
) (
  input  logic              i_AUD_BCLK,
  input  logic              i_rst_n,
  input  logic              i_frame_start,
  input  logic              i_clr_overrun,
  input  logic              i_a_req,
  input  logic              i_a_we,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_wdata,
  input  logic              i_a_done,
  input  logic              i_b_req,
  input  logic              i_b_we,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_wdata,
  input  logic              i_b_done,
  output logic              o_a_grant,
  output logic              o_b_grant,
  output logic              o_a_ack,
  output logic              o_b_ack,
  output logic [DATA_W-1:0] o_a_rdata,
  output logic [DATA_W-1:0] o_b_rdata,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_we_n,
  output logic [DATA_W-1:0] o_sram_wdata,
  output logic              o_sram_dq_oe,
  input  logic [DATA_W-1:0] i_sram_rdata,
  output logic              o_busy,
  output logic              o_overrun,
  output logic              o_timeout
);

  typedef enum logic [1:0] {
    SLOT_IDLE = 2'd0,
    SLOT_A    = 2'd1,
    SLOT_B    = 2'd2
  } slot_e;

  typedef enum logic [1:0] {
    PH_WAIT  = 2'd0,
    PH_SETUP = 2'd1,
    PH_HOLD  = 2'd2
  } phase_e;

  localparam int CNT_W = $clog2(SLOT_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_TIMEOUT);
  // cnt_q holds cycles already spent in the slot, so the current cycle is the last one
  // allowed when cnt_q reaches SLOT_TIMEOUT-1.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_TIMEOUT - 1);

  slot_e             slot_q, slot_d;
  phase_e            phase_q, phase_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              done_lat_q, done_lat_d;
  logic              overrun_q, overrun_d;
  logic              timeout_q, timeout_d;
  logic              lat_we_q, lat_we_d;
  logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
  logic [DATA_W-1:0] lat_wdata_q, lat_wdata_d;

  logic [1:0]        req_v;
  logic [1:0]        we_v;
  logic [1:0]        done_v;
  logic [ADDR_W-1:0] addr_v [2];
  logic [DATA_W-1:0] wdata_v [2];
  logic [1:0]        ack_v;
  logic [DATA_W-1:0] rdata_v [2];

  logic in_slot;
  logic own_idx;
  logic own_req;
  logic own_done;
  logic in_access;
  logic hold_end;
  logic fs_busy;
  logic expire;
  logic handover;
  logic timeout_set;

  assign req_v      = {i_b_req, i_a_req};
  assign we_v       = {i_b_we, i_a_we};
  assign done_v     = {i_b_done, i_a_done};
  assign addr_v[0]  = i_a_addr;
  assign addr_v[1]  = i_b_addr;
  assign wdata_v[0] = i_a_wdata;
  assign wdata_v[1] = i_b_wdata;

  assign in_slot   = (slot_q == SLOT_A) || (slot_q == SLOT_B);
  assign own_idx   = (slot_q == SLOT_B);
  assign own_req   = in_slot && req_v[own_idx];
  assign own_done  = in_slot && done_v[own_idx];
  assign in_access = in_slot && (phase_q != PH_WAIT);
  assign hold_end  = in_slot && (phase_q == PH_HOLD);
  assign fs_busy   = i_frame_start && in_slot;
  assign expire    = in_slot && (phase_q == PH_WAIT) && (cnt_q >= CNT_LAST);

  always_comb begin
    slot_d      = slot_q;
    phase_d     = phase_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    done_lat_d  = done_lat_q;
    lat_we_d    = lat_we_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    handover    = 1'b0;
    timeout_set = 1'b0;

    // A second frame_start while one is already pending simply re-sets the same flag.
    if (fs_busy) begin
      pend_d = 1'b1;
    end

    case (slot_q)
      SLOT_IDLE: begin
        phase_d    = PH_WAIT;
        cnt_d      = '0;
        done_lat_d = 1'b0;
        if (i_frame_start || pend_q) begin
          slot_d = SLOT_A;
          pend_d = 1'b0;
        end
      end
      SLOT_A, SLOT_B: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
        case (phase_q)
          PH_WAIT: begin
            if (done_lat_q || expire) begin
              handover    = 1'b1;
              timeout_set = expire && !done_lat_q && !(own_done && !own_req);
            end else if (own_req) begin
              phase_d     = PH_SETUP;
              lat_we_d    = we_v[own_idx];
              lat_addr_d  = addr_v[own_idx];
              lat_wdata_d = wdata_v[own_idx];
              done_lat_d  = own_done;
            end else if (own_done) begin
              handover = 1'b1;
            end
          end
          PH_SETUP: begin
            phase_d = PH_HOLD;
            if (own_done) begin
              done_lat_d = 1'b1;
            end
          end
          PH_HOLD: begin
            phase_d = PH_WAIT;
            if (own_done) begin
              done_lat_d = 1'b1;
            end
          end
          default: begin
            phase_d = PH_WAIT;
          end
        endcase
        if (handover) begin
          phase_d    = PH_WAIT;
          cnt_d      = '0;
          done_lat_d = 1'b0;
          slot_d     = (slot_q == SLOT_A) ? SLOT_B : SLOT_IDLE;
        end
      end
      default: begin
        slot_d     = SLOT_IDLE;
        phase_d    = PH_WAIT;
        cnt_d      = '0;
        done_lat_d = 1'b0;
      end
    endcase

    overrun_d = fs_busy     ? 1'b1 : (i_clr_overrun ? 1'b0 : overrun_q);
    timeout_d = timeout_set ? 1'b1 : (i_clr_overrun ? 1'b0 : timeout_q);
  end

  always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
    if (!i_rst_n) begin
      slot_q      <= SLOT_IDLE;
      phase_q     <= PH_WAIT;
      cnt_q       <= '0;
      pend_q      <= 1'b0;
      done_lat_q  <= 1'b0;
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
      lat_we_q    <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
    end else begin
      slot_q      <= slot_d;
      phase_q     <= phase_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      done_lat_q  <= done_lat_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
      lat_we_q    <= lat_we_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
    end
  end

  // Per-port ack pulse and read-data holding register; a port's rdata only moves on its own read.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic              mine;
      logic              ack_q, ack_d;
      logic [DATA_W-1:0] rdata_q, rdata_d;

      assign mine = hold_end && (own_idx == 1'(gi));

      always_comb begin
        ack_d   = mine;
        rdata_d = rdata_q;
        if (mine && !lat_we_q) begin
          rdata_d = i_sram_rdata;
        end
      end

      always_ff @(posedge i_AUD_BCLK or negedge i_rst_n) begin
        if (!i_rst_n) begin
          ack_q   <= 1'b0;
          rdata_q <= '0;
        end else begin
          ack_q   <= ack_d;
          rdata_q <= rdata_d;
        end
      end

      assign ack_v[gi]   = ack_q;
      assign rdata_v[gi] = rdata_q;
    end
  endgenerate

  assign o_a_grant = (slot_q == SLOT_A);
  assign o_b_grant = (slot_q == SLOT_B);
  assign o_a_ack   = ack_v[0];
  assign o_b_ack   = ack_v[1];
  assign o_a_rdata = rdata_v[0];
  assign o_b_rdata = rdata_v[1];
  assign o_busy    = in_slot;
  assign o_overrun = overrun_q;
  assign o_timeout = timeout_q;

  // Pins are decoded straight from registered state so an async reset releases WE_N/DQ at once.
  assign o_sram_addr  = in_access ? lat_addr_q  : '0;
  assign o_sram_wdata = in_access ? lat_wdata_q : '0;
  assign o_sram_dq_oe = in_access && lat_we_q;
  assign o_sram_we_n  = ~(in_slot && (phase_q == PH_SETUP) && lat_we_q);

endmodule

// File: tb/tb_sram_frame_arbiter.sv
// Bench for sram_frame_arbiter: a behavioural SRAM plus a write-back scoreboard of expected
// memory contents; scenario tasks run in sequence and compare against rule-derived values.
module tb_sram_frame_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_start, clr_overrun;
  logic        a_req, a_we, a_done, b_req, b_we, b_done;
  logic [19:0] a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;
  logic        a_grant, b_grant, a_ack, b_ack;
  logic [15:0] a_rdata, b_rdata;
  logic [19:0] sram_addr;
  logic        sram_we_n, sram_dq_oe;
  logic [15:0] sram_wdata, sram_rdata;
  logic        busy, overrun, timeout;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] mem [0:1023];
  logic [15:0] ref_mem [int];
  int          pool [$];

  always #5 clk = ~clk;

  sram_frame_arbiter dut (
    .i_AUD_BCLK(clk), .i_rst_n(rst_n), .i_frame_start(frame_start), .i_clr_overrun(clr_overrun),
    .i_a_req(a_req), .i_a_we(a_we), .i_a_addr(a_addr), .i_a_wdata(a_wdata), .i_a_done(a_done),
    .i_b_req(b_req), .i_b_we(b_we), .i_b_addr(b_addr), .i_b_wdata(b_wdata), .i_b_done(b_done),
    .o_a_grant(a_grant), .o_b_grant(b_grant), .o_a_ack(a_ack), .o_b_ack(b_ack),
    .o_a_rdata(a_rdata), .o_b_rdata(b_rdata), .o_sram_addr(sram_addr), .o_sram_we_n(sram_we_n),
    .o_sram_wdata(sram_wdata), .o_sram_dq_oe(sram_dq_oe), .i_sram_rdata(sram_rdata),
    .o_busy(busy), .o_overrun(overrun), .o_timeout(timeout)
  );

  // Async SRAM: a write lands while WE_N is low with DQ driven; reads are combinational.
  always @(negedge clk) begin
    if (!sram_we_n && sram_dq_oe) mem[sram_addr[9:0]] <= sram_wdata;
  end
  assign sram_rdata = mem[sram_addr[9:0]];

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic frame_pulse();
    frame_start = 1'b1;
    cyc();
    frame_start = 1'b0;
  endtask

  // Issues one access from the current WAIT cycle and returns in the ack cycle.
  task automatic do_access(input bit port, input bit we, input logic [19:0] addr,
                           input logic [15:0] wd, output int lat, output logic [15:0] rd);
    if (!port) begin
      a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wd;
    end else begin
      b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wd;
    end
    cyc();
    a_req = 1'b0;
    b_req = 1'b0;
    lat = 1;
    while (((port ? b_ack : a_ack) !== 1'b1) && lat < 8) begin
      cyc();
      lat++;
    end
    rd = port ? b_rdata : a_rdata;
  endtask

  task automatic release_slot(input bit port);
    if (!port) a_done = 1'b1; else b_done = 1'b1;
    cyc();
    a_done = 1'b0;
    b_done = 1'b0;
  endtask

  task automatic test_reset();
    tests_run++;
    if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_pins: we_n=%b dq_oe=%b required we_n=1 dq_oe=0", sram_we_n, sram_dq_oe);
    end
    tests_run++;
    if ({a_grant, b_grant, a_ack, b_ack, busy, overrun, timeout} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: grants/acks/busy/flags=%b required 0000000",
               {a_grant, b_grant, a_ack, b_ack, busy, overrun, timeout});
    end
    tests_run++;
    if (sram_addr !== 20'h0 || sram_wdata !== 16'h0) begin
      tests_failed++;
      $display("FAIL reset_bus: addr=%0h wdata=%0h required 0 0", sram_addr, sram_wdata);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_reset_mid_access();
    int acks;
    frame_pulse();
    a_req = 1'b1; a_we = 1'b1; a_addr = 20'h155; a_wdata = 16'hBEEF;
    cyc();
    a_req = 1'b0;
    tests_run++;
    if (sram_we_n !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_setup_we_n: got %b required 0", sram_we_n);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_async: we_n=%b dq_oe=%b required 1 0", sram_we_n, sram_dq_oe);
    end
    cyc();
    rst_n = 1'b1;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      cyc();
      acks += int'(a_ack);
    end
    tests_run++;
    if (acks != 0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_lost: acks=%0d busy=%b required 0 0", acks, busy);
    end
    $display("[TB] reset mid-write: we_n released, access dropped");
  endtask

  task automatic test_write_read();
    int          lat;
    logic [15:0] rd;
    frame_pulse();
    tests_run++;
    if (a_grant !== 1'b1 || busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL wr_grant: a_grant=%b busy=%b required 1 1", a_grant, busy);
    end
    a_req = 1'b1; a_we = 1'b1; a_addr = 20'h00010; a_wdata = 16'h1234;
    cyc();
    a_req = 1'b0;
    tests_run++;
    if (sram_addr !== 20'h10 || sram_we_n !== 1'b0 || sram_dq_oe !== 1'b1 || sram_wdata !== 16'h1234) begin
      tests_failed++;
      $display("FAIL wr_setup: addr=%0h we_n=%b oe=%b wdata=%0h required 10 0 1 1234",
               sram_addr, sram_we_n, sram_dq_oe, sram_wdata);
    end
    cyc();
    tests_run++;
    if (sram_addr !== 20'h10 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b1 || a_ack !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_hold: addr=%0h we_n=%b oe=%b ack=%b required 10 1 1 0",
               sram_addr, sram_we_n, sram_dq_oe, a_ack);
    end
    cyc();
    tests_run++;
    if (a_ack !== 1'b1 || sram_dq_oe !== 1'b0) begin
      tests_failed++;
      $display("FAIL wr_ack: ack=%b oe=%b required 1 0", a_ack, sram_dq_oe);
    end
    ref_mem[16] = 16'h1234;
    release_slot(1'b0);
    tests_run++;
    if (a_grant !== 1'b0 || b_grant !== 1'b1) begin
      tests_failed++;
      $display("FAIL handover_ab: a_grant=%b b_grant=%b required 0 1", a_grant, b_grant);
    end
    do_access(1'b1, 1'b0, 20'h00010, 16'h0, lat, rd);
    tests_run++;
    if (lat != 3 || rd !== 16'h1234) begin
      tests_failed++;
      $display("FAIL rd_b: latency=%0d rdata=%0h required 3 1234", lat, rd);
    end
    release_slot(1'b1);
    tests_run++;
    if (busy !== 1'b0 || b_grant !== 1'b0) begin
      tests_failed++;
      $display("FAIL end_frame: busy=%b b_grant=%b required 0 0", busy, b_grant);
    end
    $display("[TB] A wrote 0x10=1234, B read %0h latency %0d", rd, lat);
  endtask

  task automatic test_random_frames();
    int          lat, n, a;
    bit          we;
    logic [15:0] rd, wd;
    for (int f = 0; f < 6; f++) begin
      frame_pulse();
      for (int p = 0; p < 2; p++) begin
        tests_run++;
        if ((p == 0 ? a_grant : b_grant) !== 1'b1) begin
          tests_failed++;
          $display("FAIL rnd_grant f%0d p%0d: got 0 required 1", f, p);
        end
        n = $urandom_range(1, 3);
        for (int i = 0; i < n; i++) begin
          we = (pool.size() == 0) || ($urandom_range(0, 1) == 1);
          a  = we ? $urandom_range(0, 1023) : pool[$urandom_range(0, pool.size() - 1)];
          wd = 16'($urandom);
          do_access(p[0], we, 20'(a), wd, lat, rd);
          tests_run++;
          if (lat != 3 || (!we && rd !== ref_mem[a])) begin
            tests_failed++;
            $display("FAIL rnd_access f%0d p%0d we%0d addr %0h: latency=%0d rdata=%0h required 3 %0h",
                     f, p, we, a, lat, rd, we ? rd : ref_mem[a]);
          end
          if (we) begin
            ref_mem[a] = wd;
            pool.push_back(a);
          end
          $display("[TB] frame %0d port %s %s addr %0h data %0h", f, p ? "B" : "A",
                   we ? "write" : "read", a, we ? wd : rd);
        end
        release_slot(p[0]);
      end
      tests_run++;
      if (busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL rnd_idle f%0d: busy=%b required 0", f, busy);
      end
    end
  endtask

  task automatic test_timeout();
    int n;
    frame_pulse();
    n = 0;
    while (a_grant === 1'b1 && n < 30) begin
      n++;
      cyc();
    end
    tests_run++;
    if (n != 12 || b_grant !== 1'b1 || timeout !== 1'b1) begin
      tests_failed++;
      $display("FAIL timeout: a_grant cycles=%0d b_grant=%b timeout=%b required 12 1 1", n, b_grant, timeout);
    end
    release_slot(1'b1);
    clr_overrun = 1'b1;
    cyc();
    clr_overrun = 1'b0;
    tests_run++;
    if (timeout !== 1'b0) begin
      tests_failed++;
      $display("FAIL timeout_clr: got %b required 0", timeout);
    end
    $display("[TB] slot A forced off after %0d cycles", n);
  endtask

  task automatic test_back_to_back();
    logic [15:0] ack_mask, exp_mask, rd, wd [4];
    int          ad [4];
    int          lat;
    frame_pulse();
    ack_mask = '0;
    exp_mask = '0;
    for (int j = 1; j <= 4; j++) exp_mask[3*j] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      ad[j] = 256 + 4 * j + $urandom_range(0, 3);
      wd[j] = 16'($urandom);
    end
    for (int k = 0; k <= 12; k++) begin
      ack_mask[k] = a_ack;
      a_req = 1'b0;
      a_we  = 1'b1;
      if (k % 3 == 0 && k < 12) begin
        a_req = 1'b1; a_addr = 20'(ad[k/3]); a_wdata = wd[k/3];
      end else if (k == 1) begin
        a_req = 1'b1; a_addr = 20'h3FF; a_wdata = 16'hDEAD;
      end
      cyc();
    end
    a_req = 1'b0;
    tests_run++;
    if (ack_mask !== exp_mask) begin
      tests_failed++;
      $display("FAIL b2b_acks: ack cycle mask=%0h required %0h", ack_mask, exp_mask);
    end
    for (int j = 0; j < 4; j++) ref_mem[ad[j]] = wd[j];
    for (int j = 0; j < 2; j++) begin
      do_access(1'b1, 1'b0, 20'(ad[j]), 16'h0, lat, rd);
      tests_run++;
      if (lat != 3 || rd !== ref_mem[ad[j]]) begin
        tests_failed++;
        $display("FAIL b2b_readback %0d: latency=%0d rdata=%0h required 3 %0h", j, lat, rd, ref_mem[ad[j]]);
      end
    end
    release_slot(1'b1);
    clr_overrun = 1'b1;
    cyc();
    clr_overrun = 1'b0;
    $display("[TB] back-to-back A writes, ack mask %0h", ack_mask);
  endtask

  task automatic test_overrun();
    frame_pulse();
    release_slot(1'b0);
    frame_pulse();
    tests_run++;
    if (overrun !== 1'b1 || b_grant !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_set: overrun=%b b_grant=%b required 1 1", overrun, b_grant);
    end
    frame_pulse();
    release_slot(1'b1);
    tests_run++;
    if (busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL overrun_idle_gap: busy=%b required 0", busy);
    end
    cyc();
    tests_run++;
    if (a_grant !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_restart: a_grant=%b required 1", a_grant);
    end
    release_slot(1'b0);
    release_slot(1'b1);
    cyc();
    tests_run++;
    if (busy !== 1'b0 || overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL overrun_dropped: busy=%b overrun=%b required 0 1", busy, overrun);
    end
    clr_overrun = 1'b1;
    cyc();
    clr_overrun = 1'b0;
    tests_run++;
    if (overrun !== 1'b0) begin
      tests_failed++;
      $display("FAIL overrun_clr: got %b required 0", overrun);
    end
    $display("[TB] overrun during slot B handled");
  endtask

  task automatic test_b_ignored();
    int          bad;
    int          lat;
    logic [15:0] rd;
    frame_pulse();
    b_req = 1'b1; b_we = 1'b1; b_addr = 20'($urandom_range(1, 1023)); b_wdata = 16'($urandom);
    cyc();
    b_req = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (sram_addr !== 20'h0 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || b_ack !== 1'b0 || a_grant !== 1'b1)
        bad++;
      cyc();
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL b_ignored: %0d disturbed cycles required 0", bad);
    end
    do_access(1'b0, 1'b1, 20'h020, 16'h5A5A, lat, rd);
    ref_mem[32] = 16'h5A5A;
    tests_run++;
    if (lat != 3) begin
      tests_failed++;
      $display("FAIL a_after_ignored: latency=%0d required 3", lat);
    end
    release_slot(1'b0);
    release_slot(1'b1);
    $display("[TB] b_req without grant ignored");
  endtask

  initial begin
    rst_n = 1'b0;
    frame_start = 1'b0; clr_overrun = 1'b0;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0; a_done = 1'b0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0; b_done = 1'b0;
    cyc();
    test_reset();
    cyc();
    rst_n = 1'b1;
    cyc();
    test_reset_mid_access();
    test_write_read();
    test_random_frames();
    test_timeout();
    test_back_to_back();
    test_overrun();
    test_b_ignored();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
